// File: rtl/gpr_write_scheduler_if.sv
// gpr_wsched_if: request/clear/bank bus for gpr_write_scheduler.
//   req_valid/req_ready : per-requester handshake (NREQ)
//   req_idx             : flat 4-bit target index per requester
//   req_data            : flat DW-bit write data per requester
//   clr_start           : one-cycle pulse requesting a sequenced clear
//   we/wdata            : per-register write enable / data to the bank
//   busy/clr_done       : clear sequence status
// master = requester/bank side, slave = scheduler.
interface gpr_wsched_if #(
  parameter int NREQ = 3,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*4-1:0]  req_idx;
  logic [NREQ*DW-1:0] req_data;
  logic               clr_start;
  logic [15:0]        we;
  logic [DW-1:0]      wdata [15:0];
  logic               busy;
  logic               clr_done;

  modport master (
    output req_valid, req_idx, req_data, clr_start,
    input  req_ready, we, wdata, busy, clr_done
  );

  modport slave (
    input  req_valid, req_idx, req_data, clr_start,
    output req_ready, we, wdata, busy, clr_done
  );
endinterface

// File: rtl/gpr_write_scheduler.sv
// gpr_write_scheduler: arbitrates NREQ write requesters onto a 16-entry
// register bank. Per target register the first valid requester in
// round-robin order (starting at rr_ptr) wins; requesters aimed at
// different registers are all granted in the same cycle. A clr_start
// pulse runs a 16-cycle clear (one register per cycle) during which no
// requests are accepted.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : gpr_wsched_if.slave (requests, clear control, bank writes)
// Build option: GPR_WSCHED_R0_LOCK_EN -- requests to register 0 still
//   handshake but never write it; the clear sequence still zeroes it.
module gpr_write_scheduler #(
  parameter int NREQ = 3,
  parameter int DW   = 32
) (
  input  logic         clk,
  input  logic         rst,
  gpr_wsched_if.slave  bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [PW-1:0]   r_rr_ptr;
  logic            r_busy;
  logic            r_clr_done;
  logic [15:0]     r_we;
  logic [DW-1:0]   r_wdata [15:0];

  logic [NREQ-1:0][3:0]    w_idx;
  logic [NREQ-1:0][DW-1:0] w_data;
  logic [NREQ-1:0]         w_grant;
  int                      w_dist [NREQ];
  logic [15:0]             w_we_nxt;
  logic [DW-1:0]           w_wd_nxt [15:0];

  assign w_idx  = bus.req_idx;
  assign w_data = bus.req_data;

  // Priority distance of each requester from the round-robin pointer.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      if (k >= int'(r_rr_ptr)) w_dist[k] = k - int'(r_rr_ptr);
      else                     w_dist[k] = k + NREQ - int'(r_rr_ptr);
    end
  end

  // A valid requester loses only to a closer valid requester hitting
  // the same register, so each register gets at most one grant.
  always_comb begin
    w_grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_grant[k] = bus.req_valid[k];
      for (int j = 0; j < NREQ; j++) begin
        if (j != k && bus.req_valid[j] && w_idx[j] == w_idx[k] &&
            w_dist[j] < w_dist[k])
          w_grant[k] = 1'b0;
      end
    end
    if (!rst || r_state == ST_CLEAR || bus.clr_start) w_grant = '0;
  end

  // Bank writes produced by this cycle's handshakes; untouched entries hold.
  always_comb begin
    w_we_nxt = '0;
    w_wd_nxt = r_wdata;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant[k]) begin
        w_we_nxt[w_idx[k]] = 1'b1;
        w_wd_nxt[w_idx[k]] = w_data[k];
      end
    end
`ifdef GPR_WSCHED_R0_LOCK_EN
    w_we_nxt[0] = 1'b0;
    w_wd_nxt[0] = r_wdata[0];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rr_ptr   <= '0;
      r_busy     <= 1'b0;
      r_clr_done <= 1'b0;
      r_we       <= '0;
      for (int i = 0; i < 16; i++) r_wdata[i] <= '0;
    end else begin
      r_clr_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_we    <= w_we_nxt;
          r_wdata <= w_wd_nxt;
          if (bus.clr_start) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_we           <= 16'(1) << r_cnt;
          r_wdata[r_cnt] <= '0;
          r_cnt          <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_clr_done <= 1'b1;   // lands with we[15]
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (|w_grant)
        r_rr_ptr <= (r_rr_ptr == PW'(NREQ-1)) ? '0 : r_rr_ptr + 1'b1;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.we        = r_we;
  assign bus.wdata     = r_wdata;
  assign bus.busy      = r_busy;
  assign bus.clr_done  = r_clr_done;
endmodule

// File: tb/tb_gpr_write_scheduler.sv
module tb_gpr_write_scheduler;
  localparam int NREQ = 3;
  localparam int DW   = 32;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  gpr_wsched_if #(.NREQ(NREQ), .DW(DW)) u_if ();

  gpr_write_scheduler #(.NREQ(NREQ), .DW(DW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [3:0] idx,
                         input logic [DW-1:0] d);
    u_if.req_valid[k]        = v;
    u_if.req_idx[4*k +: 4]   = idx;
    u_if.req_data[DW*k +: DW] = d;
  endtask

  int ndone;
  int nwe;

  initial begin
    nvec = 0;
    nerr = 0;
    rst  = 1'b0;
    u_if.req_valid = '0;
    u_if.req_idx   = '0;
    u_if.req_data  = '0;
    u_if.clr_start = 1'b0;

    // reset state, with requests pending
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 4'd7, 32'h100 + k);
    #12;
    chk("rst_ready", u_if.req_ready, 3'b000);
    chk("rst_we",    u_if.we, 16'h0);
    chk("rst_busy",  u_if.busy, 1'b0);
    chk("rst_done",  u_if.clr_done, 1'b0);
    chk("rst_wd7",   u_if.wdata[7], 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;

    // three requesters on idx 7: rotation req0, req1, req2, req0
    for (int i = 0; i < 4; i++) begin
      chk("rr_ready", u_if.req_ready, 3'b001 << (i % 3));
      tick();
      chk("rr_we",  u_if.we, 16'h0080);
      chk("rr_wd7", u_if.wdata[7], 32'h100 + (i % 3));
    end
    u_if.req_valid = '0;
    tick();
    chk("rr_we_off", u_if.we, 16'h0);
    chk("rr_wd7_hold", u_if.wdata[7], 32'h100);

    // two requesters on different registers, same cycle
    set_req(0, 1'b1, 4'd2, 32'hAAAA0001);
    set_req(1, 1'b1, 4'd5, 32'h5);
    #1;
    chk("par_ready", u_if.req_ready, 3'b011);
    tick();
    u_if.req_valid = '0;
    chk("par_we",  u_if.we, 16'h0024);
    chk("par_wd2", u_if.wdata[2], 32'hAAAA0001);
    chk("par_wd5", u_if.wdata[5], 32'h5);

    // write to register 0
    set_req(2, 1'b1, 4'd0, 32'h1234);
    #1;
    chk("r0_ready", u_if.req_ready, 3'b100);
    tick();
    u_if.req_valid = '0;
`ifdef GPR_WSCHED_R0_LOCK_EN
    chk("r0_we",  u_if.we, 16'h0000);
    chk("r0_wd0", u_if.wdata[0], 32'h0);
`else
    chk("r0_we",  u_if.we, 16'h0001);
    chk("r0_wd0", u_if.wdata[0], 32'h1234);
`endif
    chk("r0_wd2_hold", u_if.wdata[2], 32'hAAAA0001);

    // clear sequence with req1 pending
    set_req(1, 1'b1, 4'd9, 32'hBEEF);
    u_if.clr_start = 1'b1;
    #1;
    chk("clr_ready_T", u_if.req_ready, 3'b000);
    tick();
    u_if.clr_start = 1'b0;
    #1;
    chk("clr_busy_T1",  u_if.busy, 1'b1);
    chk("clr_we_T1",    u_if.we, 16'h0);
    chk("clr_ready_T1", u_if.req_ready, 3'b000);
    for (int j = 0; j < 16; j++) begin
      tick();
      chk("clr_we",   u_if.we, 16'h0001 << j);
      chk("clr_busy", u_if.busy, (j < 15) ? 1'b1 : 1'b0);
      chk("clr_done", u_if.clr_done, (j == 15) ? 1'b1 : 1'b0);
    end
    chk("clr_ready_T17", u_if.req_ready, 3'b010);
    chk("clr_wd2", u_if.wdata[2], 32'h0);
    chk("clr_wd5", u_if.wdata[5], 32'h0);
    chk("clr_wd0", u_if.wdata[0], 32'h0);
    tick();
    u_if.req_valid = '0;
    chk("post_we",   u_if.we, 16'h0200);
    chk("post_wd9",  u_if.wdata[9], 32'hBEEF);
    chk("post_done", u_if.clr_done, 1'b0);

    // reset in the middle of a clear, clr_start re-pulsed while clearing
    u_if.clr_start = 1'b1;
    tick();
    u_if.clr_start = 1'b0;
    tick();
    tick();
    u_if.clr_start = 1'b1;
    tick();
    u_if.clr_start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_we_pre", u_if.we, 16'h0020);
    rst = 1'b0;
    #1;
    chk("abort_we",   u_if.we, 16'h0);
    chk("abort_busy", u_if.busy, 1'b0);
    chk("abort_done", u_if.clr_done, 1'b0);
    #2;
    rst = 1'b1;
    ndone = 0;
    nwe   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (u_if.clr_done) ndone++;
      if (u_if.we != 16'h0) nwe++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_no_we",   nwe, 0);
    set_req(0, 1'b1, 4'd3, 32'h77);
    #1;
    chk("after_ready", u_if.req_ready, 3'b001);
    tick();
    u_if.req_valid = '0;
    chk("after_we",  u_if.we, 16'h0008);
    chk("after_wd3", u_if.wdata[3], 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
